// File: rtl/regroup_lookup_arbiter_if.sv
// rtl/regroup_lookup_arbiter_if.sv - channel and lookup-table signal bundle for the regroup lookup arbiter
interface regroup_lookup_arbiter_if #(
    parameter int PORT_NUM = 4,
    parameter int KEY_W    = 14
);
    logic [PORT_NUM-1:0]       iv_req;
    logic [PORT_NUM*KEY_W-1:0] iv_req_key;
    logic [PORT_NUM-1:0]       iv_done;
    logic [KEY_W-1:0]          ov_lookup_key;
    logic                      o_lookup_key_wr;
    logic [56:0]               iv_lookup_result;
    logic                      i_lookup_match_flag;
    logic                      i_lookup_result_wr;
    logic [PORT_NUM-1:0]       ov_grant;
    logic [56:0]               ov_dmac_outport;
    logic                      o_lookup_table_match_flag;
    logic [PORT_NUM-1:0]       ov_dmac_outport_wr;

    modport slave (
        input  iv_req, iv_req_key, iv_done,
        input  iv_lookup_result, i_lookup_match_flag, i_lookup_result_wr,
        output ov_lookup_key, o_lookup_key_wr,
        output ov_grant, ov_dmac_outport, o_lookup_table_match_flag, ov_dmac_outport_wr
    );

    modport master (
        output iv_req, iv_req_key, iv_done,
        output iv_lookup_result, i_lookup_match_flag, i_lookup_result_wr,
        input  ov_lookup_key, o_lookup_key_wr,
        input  ov_grant, ov_dmac_outport, o_lookup_table_match_flag, ov_dmac_outport_wr
    );
endinterface

// File: rtl/regroup_lookup_arbiter.sv
// rtl/regroup_lookup_arbiter.sv - round-robin arbiter sharing one lookup table among PORT_NUM regroup channels
// Optional statistics counters are built when REGROUP_ARB_STAT_EN is defined.
module regroup_lookup_arbiter #(
    parameter int PORT_NUM       = 4,
    parameter int KEY_W          = 14,
    parameter int LOOKUP_TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    regroup_lookup_arbiter_if.slave bus
`ifdef REGROUP_ARB_STAT_EN
    ,
    output logic [PORT_NUM*16-1:0] ov_grant_cnt,
    output logic [15:0]            ov_timeout_cnt,
    output logic [15:0]            ov_stray_cnt
`endif
);

    localparam int IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE_S        = 2'd0,
        LOOKUP_S      = 2'd1,
        WAIT_RESULT_S = 2'd2,
        HOLD_S        = 2'd3
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    rr_q;
    logic [IDX_W-1:0]    owner_q;
    logic [7:0]          tmo_q;
    logic [7:0]          tmo_d;
    logic [PORT_NUM-1:0] grant_q;
    logic [KEY_W-1:0]    key_q;
    logic                key_wr_q;
    logic [56:0]         result_q;
    logic                match_q;
    logic [PORT_NUM-1:0] result_wr_q;

    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [PORT_NUM-1:0] sel_onehot;
    logic [KEY_W-1:0]    sel_key;
    int                  scan_c;
    logic                tmo_hit;
    logic                tmo_fire;
    logic [IDX_W-1:0]    rr_next;

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_c    = 0;
        for (int i = 0; i < PORT_NUM; i++) begin
            scan_c = (int'(rr_q) + i) % PORT_NUM;
            if (!sel_found && bus.iv_req[scan_c]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(scan_c);
            end
        end
    end

    always_comb begin
        sel_key = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            if (sel_idx == IDX_W'(k)) begin
                sel_key = bus.iv_req_key[k*KEY_W +: KEY_W];
            end
        end
    end

    assign sel_onehot = PORT_NUM'(1) << sel_idx;
    assign tmo_d      = tmo_q + 8'd1;
    assign tmo_hit    = (tmo_d == 8'(LOOKUP_TIMEOUT));
    // A real result in the expiry cycle wins over the forced miss.
    assign tmo_fire   = (state_q == WAIT_RESULT_S) && !bus.i_lookup_result_wr && tmo_hit;
    assign rr_next    = (owner_q == IDX_W'(PORT_NUM - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE_S;
            rr_q        <= '0;
            owner_q     <= '0;
            tmo_q       <= '0;
            grant_q     <= '0;
            key_q       <= '0;
            key_wr_q    <= 1'b0;
            result_q    <= '0;
            match_q     <= 1'b0;
            result_wr_q <= '0;
        end else begin
            key_wr_q    <= 1'b0;
            result_wr_q <= '0;
            case (state_q)
                IDLE_S: begin
                    if (sel_found) begin
                        grant_q  <= sel_onehot;
                        owner_q  <= sel_idx;
                        key_q    <= sel_key;
                        key_wr_q <= 1'b1;
                        state_q  <= LOOKUP_S;
                    end
                end
                LOOKUP_S: begin
                    tmo_q   <= '0;
                    state_q <= WAIT_RESULT_S;
                end
                WAIT_RESULT_S: begin
                    if (bus.i_lookup_result_wr) begin
                        result_q    <= bus.iv_lookup_result;
                        match_q     <= bus.i_lookup_match_flag;
                        result_wr_q <= grant_q;
                        state_q     <= HOLD_S;
                    end else if (tmo_hit) begin
                        result_q    <= '0;
                        match_q     <= 1'b0;
                        result_wr_q <= grant_q;
                        state_q     <= HOLD_S;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                HOLD_S: begin
                    if (bus.iv_done[owner_q]) begin
                        grant_q <= '0;
                        rr_q    <= rr_next;
                        state_q <= IDLE_S;
                    end
                end
                default: state_q <= IDLE_S;
            endcase
        end
    end

    assign bus.ov_lookup_key             = key_q;
    assign bus.o_lookup_key_wr           = key_wr_q;
    assign bus.ov_grant                  = grant_q;
    assign bus.ov_dmac_outport           = result_q;
    assign bus.o_lookup_table_match_flag = match_q;
    assign bus.ov_dmac_outport_wr        = result_wr_q;

`ifdef REGROUP_ARB_STAT_EN
    logic [15:0] grant_cnt_q [PORT_NUM];
    logic [15:0] timeout_cnt_q;
    logic [15:0] stray_cnt_q;
    logic        stray_hit;

    assign stray_hit = bus.i_lookup_result_wr && (state_q != WAIT_RESULT_S);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < PORT_NUM; k++) begin
                grant_cnt_q[k] <= '0;
            end
            timeout_cnt_q <= '0;
            stray_cnt_q   <= '0;
        end else begin
            if ((state_q == LOOKUP_S) && (grant_cnt_q[owner_q] != 16'hFFFF)) begin
                grant_cnt_q[owner_q] <= grant_cnt_q[owner_q] + 16'd1;
            end
            if (tmo_fire && (timeout_cnt_q != 16'hFFFF)) begin
                timeout_cnt_q <= timeout_cnt_q + 16'd1;
            end
            if (stray_hit && (stray_cnt_q != 16'hFFFF)) begin
                stray_cnt_q <= stray_cnt_q + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < PORT_NUM; g++) begin : g_grant_cnt
        assign ov_grant_cnt[g*16 +: 16] = grant_cnt_q[g];
    end
    assign ov_timeout_cnt = timeout_cnt_q;
    assign ov_stray_cnt   = stray_cnt_q;
`else
    logic unused_tmo_fire;
    assign unused_tmo_fire = tmo_fire;
`endif

endmodule

// File: tb/tb_regroup_lookup_arbiter.sv
// tb/tb_regroup_lookup_arbiter.sv - self-checking bench for regroup_lookup_arbiter
module tb_regroup_lookup_arbiter;
    localparam int PN  = 4;
    localparam int KW  = 14;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regroup_lookup_arbiter_if #(.PORT_NUM(PN), .KEY_W(KW)) bus();

`ifdef REGROUP_ARB_STAT_EN
    logic [PN*16-1:0] grant_cnt;
    logic [15:0]      timeout_cnt;
    logic [15:0]      stray_cnt;
`endif

    regroup_lookup_arbiter #(.PORT_NUM(PN), .KEY_W(KW), .LOOKUP_TIMEOUT(TMO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
`ifdef REGROUP_ARB_STAT_EN
        ,
        .ov_grant_cnt   (grant_cnt),
        .ov_timeout_cnt (timeout_cnt),
        .ov_stray_cnt   (stray_cnt)
`endif
    );

    typedef struct {
        logic [3:0]  wr;
        logic [56:0] data;
        logic        flag;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  grant;
        int          d;
        logic [56:0] res;
        logic        match;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[5];
    logic [13:0] key_tab [4];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int idx_of(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    // Scoreboard: every result strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.ov_dmac_outport_wr != '0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_wr", 64'(bus.ov_dmac_outport_wr), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_wr",   64'(bus.ov_dmac_outport_wr), 64'(mon_e.wr));
                chk("sb_data", 64'(bus.ov_dmac_outport), 64'(mon_e.data));
                chk("sb_flag", 64'(bus.o_lookup_table_match_flag), 64'(mon_e.flag));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.iv_req = '0;
        bus.iv_done = '0;
        bus.i_lookup_result_wr = 1'b0;
        bus.i_lookup_match_flag = 1'b0;
        bus.iv_lookup_result = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_grant"}, 64'(bus.ov_grant), 64'd0);
        chk({nm, "_key"},   64'(bus.ov_lookup_key), 64'd0);
        chk({nm, "_keywr"}, 64'(bus.o_lookup_key_wr), 64'd0);
        chk({nm, "_data"},  64'(bus.ov_dmac_outport), 64'd0);
        chk({nm, "_flag"},  64'(bus.o_lookup_table_match_flag), 64'd0);
        chk({nm, "_wr"},    64'(bus.ov_dmac_outport_wr), 64'd0);
    endtask

    task automatic drive_result(input logic [3:0] g, input logic [56:0] r, input logic m);
        bus.iv_lookup_result = r;
        bus.i_lookup_match_flag = m;
        bus.i_lookup_result_wr = 1'b1;
        sb_q.push_back('{wr: g, data: r, flag: m});
    endtask

    task automatic run_vec(input vec_t v);
        bus.iv_req = v.req;
        step();
        chk("vec_grant", 64'(bus.ov_grant), 64'(v.grant));
        chk("vec_key", 64'(bus.ov_lookup_key), 64'(key_tab[idx_of(v.grant)]));
        chk("vec_key_wr", 64'(bus.o_lookup_key_wr), 64'd1);
        step();
        chk("vec_key_wr_clear", 64'(bus.o_lookup_key_wr), 64'd0);
        repeat (v.d - 1) step();
        drive_result(v.grant, v.res, v.match);
        step();
        bus.i_lookup_result_wr = 1'b0;
        bus.iv_lookup_result = ~v.res;
        bus.i_lookup_match_flag = ~v.match;
        chk("vec_wr_latency", 64'(bus.ov_dmac_outport_wr), 64'(v.grant));
        step();
        chk("vec_wr_single", 64'(bus.ov_dmac_outport_wr), 64'd0);
        chk("vec_hold_grant", 64'(bus.ov_grant), 64'(v.grant));
        chk("vec_hold_data", 64'(bus.ov_dmac_outport), 64'(v.res));
        chk("vec_hold_flag", 64'(bus.o_lookup_table_match_flag), 64'(v.match));
        bus.iv_done = v.grant;
        bus.iv_req = '0;
        step();
        bus.iv_done = '0;
        chk("vec_release", 64'(bus.ov_grant), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int ptr;
        logic [3:0] exp_g;

        key_tab[0] = 14'h1A00;
        key_tab[1] = 14'h2B11;
        key_tab[2] = 14'h0123;
        key_tab[3] = 14'h3C33;
        bus.iv_req_key = {key_tab[3], key_tab[2], key_tab[1], key_tab[0]};

        vecs[0] = '{req: 4'b0100, grant: 4'b0100, d: 3,  res: 57'h0_0001_2345_6789_ABCD, match: 1'b1};
        vecs[1] = '{req: 4'b0011, grant: 4'b0001, d: 1,  res: 57'h0_0000_DEAD_BEEF_0042, match: 1'b0};
        vecs[2] = '{req: 4'b1001, grant: 4'b1000, d: 15, res: 57'h1FF_FFFF_FFFF_FFFF,    match: 1'b1};
        vecs[3] = '{req: 4'b1111, grant: 4'b0001, d: 16, res: 57'h0AB_CDEF_0123_4567,    match: 1'b1};
        vecs[4] = '{req: 4'b0110, grant: 4'b0010, d: 5,  res: 57'h055_AA55_AA55_AA55,    match: 1'b0};

        do_reset();
        chk_all_zero("reset");

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
`ifdef REGROUP_ARB_STAT_EN
        chk("stat_no_timeout_on_collision", 64'(timeout_cnt), 64'd0);
        chk("stat_no_stray", 64'(stray_cnt), 64'd0);
`endif

        // Round robin with every channel requesting continuously.
        do_reset();
        bus.iv_req = 4'b1111;
        ptr = 0;
        for (int n = 0; n < 5; n++) begin
            exp_g = 4'b0001 << ptr;
            step();
            chk("rr_grant", 64'(bus.ov_grant), 64'(exp_g));
            chk("rr_key", 64'(bus.ov_lookup_key), 64'(key_tab[ptr]));
            step();
            drive_result(exp_g, 57'(n) + 57'h100, 1'b1);
            step();
            bus.i_lookup_result_wr = 1'b0;
            step();
            bus.iv_done = exp_g;
            step();
            bus.iv_done = '0;
            chk("rr_idle_gap", 64'(bus.ov_grant), 64'd0);
            ptr = (ptr + 1) % PN;
        end
        bus.iv_req = '0;
        step();

        // Timeout: no result for ch1, forced miss, then a stray strobe.
        do_reset();
        bus.iv_req = 4'b0010;
        step();
        chk("tmo_grant", 64'(bus.ov_grant), 64'b0010);
        sb_q.push_back('{wr: 4'b0010, data: 57'd0, flag: 1'b0});
        bus.iv_lookup_result = 57'h1_5555_AAAA_5555;
        bus.i_lookup_match_flag = 1'b1;
        cnt = 0;
        while (cnt < 40) begin
            step();
            cnt++;
            if (bus.ov_dmac_outport_wr != '0) break;
        end
        chk("tmo_latency", 64'(cnt), 64'(TMO + 1));
        step();
        chk("tmo_hold_grant", 64'(bus.ov_grant), 64'b0010);
        bus.i_lookup_result_wr = 1'b1;
        step();
        bus.i_lookup_result_wr = 1'b0;
        step();
        chk("stray_no_wr", 64'(bus.ov_dmac_outport_wr), 64'd0);
        chk("stray_data_zero", 64'(bus.ov_dmac_outport), 64'd0);
        chk("stray_flag_zero", 64'(bus.o_lookup_table_match_flag), 64'd0);
`ifdef REGROUP_ARB_STAT_EN
        chk("stat_stray", 64'(stray_cnt), 64'd1);
        chk("stat_timeout", 64'(timeout_cnt), 64'd1);
        chk("stat_grant_ch1", 64'(grant_cnt[16 +: 16]), 64'd1);
`endif
        bus.iv_done = 4'b0010;
        bus.iv_req = '0;
        step();
        bus.iv_done = '0;
        chk("tmo_release", 64'(bus.ov_grant), 64'd0);

        // Non-owner done and owner dropping its request are both ignored.
        do_reset();
        bus.iv_req = 4'b0001;
        step();
        chk("wd_grant0", 64'(bus.ov_grant), 64'b0001);
        step();
        drive_result(4'b0001, 57'h55, 1'b0);
        step();
        bus.i_lookup_result_wr = 1'b0;
        step();
        bus.iv_req = 4'b1001;
        bus.iv_done = 4'b1000;
        step();
        bus.iv_done = '0;
        chk("wd_wrong_done", 64'(bus.ov_grant), 64'b0001);
        bus.iv_req = 4'b1000;
        step();
        chk("wd_req_drop", 64'(bus.ov_grant), 64'b0001);
        bus.iv_req = 4'b1001;
        bus.iv_done = 4'b0001;
        step();
        bus.iv_done = '0;
        chk("wd_release", 64'(bus.ov_grant), 64'd0);
        step();
        chk("wd_next_grant", 64'(bus.ov_grant), 64'b1000);
        chk("wd_next_key", 64'(bus.ov_lookup_key), 64'(key_tab[3]));
        step();
        drive_result(4'b1000, 57'h77, 1'b1);
        step();
        bus.i_lookup_result_wr = 1'b0;
        step();
        bus.iv_done = 4'b1000;
        bus.iv_req = '0;
        step();
        bus.iv_done = '0;

        // Reset while waiting for a result.
        do_reset();
        bus.iv_req = 4'b0001;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.iv_req = '0;
        chk_all_zero("midrst");
        bus.iv_lookup_result = 57'h0ABC;
        bus.i_lookup_match_flag = 1'b1;
        bus.i_lookup_result_wr = 1'b1;
        step();
        bus.i_lookup_result_wr = 1'b0;
        chk("midrst_late_wr", 64'(bus.ov_dmac_outport_wr), 64'd0);
        chk("midrst_late_data", 64'(bus.ov_dmac_outport), 64'd0);
        step();
        chk("midrst_late_wr2", 64'(bus.ov_dmac_outport_wr), 64'd0);
        run_vec('{req: 4'b0001, grant: 4'b0001, d: 2, res: 57'h0_1234_0000_5678, match: 1'b1});

        step();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
